// File: rtl/fp16_pkg.sv
// Shared FP16 constants, unpacked-operand type and accumulator FSM states.
package fp16_pkg;

  localparam int          EXP_W    = 5;
  localparam int          FRAC_W   = 10;
  localparam int          EXP_BIAS = 15;
  localparam int          EMIN     = -14;
  localparam logic [14:0] SAT_MAG  = 15'h7FFF;
  localparam int          SIG_W    = FRAC_W + 1;

  typedef struct packed {
    logic                sign;
    logic signed [6:0]   exp;
    logic [SIG_W-1:0]    sig;
  } unpacked_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } state_t;

  // Denormals read as exponent EMIN with a clear hidden bit.
  function automatic unpacked_t unpack(input logic [15:0] v);
    unpacked_t        u;
    logic [EXP_W-1:0] field;
    field  = v[14:10];
    u.sign = v[15];
    if (field == '0) begin
      u.exp = 7'(EMIN);
      u.sig = {1'b0, v[FRAC_W-1:0]};
    end else begin
      u.exp = 7'(int'(field) - EXP_BIAS);
      u.sig = {1'b1, v[FRAC_W-1:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/fpacc_lod.sv
// Leading-one detector over the pre-normalization significand (carry + 11 bits).
module fpacc_lod
  import fp16_pkg::*;
#(
  parameter int W    = 12,
  parameter int LZ_W = 4
) (
  input  logic [W-1:0]    sig_i,
  output logic [LZ_W-1:0] lz_o,
  output logic            zero_o
);

  // Ascending scan: the highest set bit is the last one to write lz_o.
  always_comb begin
    lz_o   = '0;
    zero_o = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (sig_i[i]) begin
        lz_o   = LZ_W'(W - 1 - i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp16_accum.sv
// FP16 packet accumulator with a four-state add pipeline (align/add/normalize/output).
// Define FPACC_RNE_EN for round-to-nearest-even; default build truncates.
module fp16_accum
  import fp16_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int GUARD_W = 3
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [15:0]      prod_i,
  input  logic             prod_valid_i,
  input  logic             prod_last_i,
  output logic             prod_ready_o,
  output logic [15:0]      acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  // Aligned operands carry GUARD_W guard bits plus one sticky bit; the sum adds a carry.
  localparam int AW = SIG_W + GUARD_W + 1;
  localparam int SW = AW + 1;

  state_t            state_q, state_d;
  logic [15:0]       prod_q, prod_d, acc_q, acc_d;
  logic              last_q, last_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     bigAl_q, bigAl_d, smallAl_q, smallAl_d;
  logic signed [6:0] expBig_q, expBig_d;
  logic              signBig_q, signBig_d, signSmall_q, signSmall_d;
  logic              special_q, special_d, resSign_q, resSign_d;
  logic [SW-1:0]     sum_q, sum_d;

  unpacked_t             opAcc, opProd, opBig, opSmall;
  logic                  accBigger;
  logic [6:0]            expDiff;
  logic [AW-2:0]         smallExt;
  logic [2*(AW-1)-1:0]   shiftWide;
  logic [SW-1:0]         sumAdd;

  logic [3:0]            lodLz, lShift;
  logic                  lodZero;
  logic [6:0]            denormRoom;
  logic signed [6:0]     expNorm, expBiased;
  logic [SW-1:0]         nSig;
  logic [EXP_W-1:0]      field;
  logic [14:0]           mag, magR;
  logic                  expOvf, satNorm;
  logic                  unusedBits;

  fpacc_lod #(.W(SIG_W + 1), .LZ_W(4)) u_lod (
    .sig_i  (sum_q[SW-1 -: SIG_W + 1]),
    .lz_o   (lodLz),
    .zero_o (lodZero)
  );

  // Align: the larger magnitude (ties to the accumulator) keeps its exponent.
  always_comb begin
    opAcc     = unpack(acc_q);
    opProd    = unpack(prod_q);
    accBigger = acc_q[14:0] >= prod_q[14:0];
    opBig     = accBigger ? opAcc : opProd;
    opSmall   = accBigger ? opProd : opAcc;
    expDiff   = 7'(opBig.exp - opSmall.exp);
    smallExt  = {opSmall.sig, {GUARD_W{1'b0}}};
    shiftWide = {smallExt, {(AW-1){1'b0}}} >> expDiff;
    if (expDiff >= 7'(AW - 1)) begin
      smallAl_d = {{(AW-1){1'b0}}, |smallExt};
    end else begin
      smallAl_d = {shiftWide[2*(AW-1)-1 -: AW-1], |shiftWide[AW-2:0]};
    end
    bigAl_d     = {opBig.sig, {(GUARD_W+1){1'b0}}};
    expBig_d    = opBig.exp;
    signBig_d   = opBig.sign;
    signSmall_d = opSmall.sign;
    special_d   = (acc_q[14:10] == 5'h1F) || (prod_q[14:10] == 5'h1F);
  end

  // Add: a zero sum is -0 only when both operands were negative.
  always_comb begin
    if (signBig_q == signSmall_q) begin
      sumAdd = {1'b0, bigAl_q} + {1'b0, smallAl_q};
    end else begin
      sumAdd = {1'b0, bigAl_q} - {1'b0, smallAl_q};
    end
    resSign_d = (sumAdd == '0) ? (signBig_q & signSmall_q) : signBig_q;
    sum_d     = sumAdd;
  end

  // Normalize: a zero LOD result means only the top guard bit can be set (shift by SIG_W).
  always_comb begin
    denormRoom = 7'(expBig_q - 7'(EMIN));
    lShift     = '0;
    if (sum_q[SW-1]) begin
      nSig    = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      expNorm = expBig_q + 7'sd1;
    end else begin
      lShift = lodZero ? 4'(SIG_W) : lodLz - 4'd1;
      if ({3'b000, lShift} > denormRoom) begin
        lShift = denormRoom[3:0];
      end
      nSig    = sum_q << lShift;
      expNorm = expBig_q - $signed({3'b000, lShift});
    end
    expBiased = expNorm + 7'sd15;
    field     = nSig[SW-2] ? expBiased[EXP_W-1:0] : '0;
    expOvf    = expNorm > 7'sd15;
    mag       = {field, nSig[SW-3 -: FRAC_W]};
`ifdef FPACC_RNE_EN
    magR = mag + 15'(nSig[GUARD_W] & ((|nSig[GUARD_W-1:0]) | nSig[GUARD_W+1]));
`else
    magR = mag;
`endif
    satNorm = special_q || expOvf || (magR[14:10] == 5'h1F);
  end

`ifdef FPACC_RNE_EN
  assign unusedBits = ^{nSig[SW-1], expBiased[6:EXP_W]};
`else
  assign unusedBits = ^{nSig[SW-1], nSig[GUARD_W:0], expBiased[6:EXP_W]};
`endif

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    last_d  = last_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (prod_valid_i) begin
          prod_d  = prod_i;
          last_d  = prod_last_i;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (!ovf_q) begin
          if (satNorm) begin
            acc_d = {signBig_q, SAT_MAG};
            ovf_d = 1'b1;
          end else begin
            acc_d = {resSign_q, magR};
          end
        end
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (acc_ready_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      bigAl_q     <= '0;
      smallAl_q   <= '0;
      expBig_q    <= '0;
      signBig_q   <= 1'b0;
      signSmall_q <= 1'b0;
      special_q   <= 1'b0;
      resSign_q   <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (state_q == S_ALIGN) begin
        bigAl_q     <= bigAl_d;
        smallAl_q   <= smallAl_d;
        expBig_q    <= expBig_d;
        signBig_q   <= signBig_d;
        signSmall_q <= signSmall_d;
        special_q   <= special_d;
      end
      if (state_q == S_ADD) begin
        sum_q     <= sum_d;
        resSign_q <= resSign_d;
      end
    end
  end

  assign prod_ready_o = (state_q == S_IDLE);
  assign acc_valid_o  = (state_q == S_OUT);
  assign acc_o        = acc_q;
  assign cnt_o        = cnt_q;
  assign ovf_o        = ovf_q;

endmodule

// File: doc/fp16_accum.md
Name: fp16_accum

Overview:
- Downstream consumer of the FP16 multiplier output (1-5-10, bias 15, denormals supported, truncating).
- Sums a packet of products into one FP16 dot-product result using a multi-cycle add FSM.
- Uses valid/ready in and out; a packet ends with the product flagged last.
- Feeds the result writeback stage.

Parameters:
- CNT_W, 8, width of element counter cnt_o; counter saturates at all-ones.
- GUARD_W, 3, guard bits kept below the mantissa LSB during alignment.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, synchronous, active-low
- prod_i  in  16  FP16 product
- prod_valid_i  in  1  prod_i valid
- prod_last_i  in  1  final product of packet
- prod_ready_o  out  1  accumulator can accept
- acc_o  out  16  accumulated FP16 result
- acc_valid_o  out  1  acc_o valid
- acc_ready_i  in  1  downstream accepts acc_o
- cnt_o  out  CNT_W  products summed in current packet
- ovf_o  out  1  sticky saturation flag for current packet

Behaviour:
- Reset (rstn_i low at a clk_i edge, any state):
  - state=S_IDLE; accumulator=+0 (0x0000); cnt_o=0; ovf_o=0; acc_valid_o=0; last flag=0.
  - prod_ready_o=1 from the following cycle.
- States: S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT.
  - S_IDLE: prod_ready_o=1. On prod_valid_i at edge N, latch prod_i and prod_last_i, then go to S_ALIGN.
  - S_ALIGN (edge N+1):
    - Unpack both operands to sign, signed 7-bit unbiased exponent, 11-bit significand.
    - Denormal: exponent -14, hidden bit 0.
    - Right-shift the smaller-exponent significand by the difference into 11+GUARD_W bits; bits beyond are ORed into a sticky bit.
    - Shift ≥14 leaves sticky only.
  - S_ADD (edge N+2): signed-magnitude add/sub with a carry bit; result sign is the sign of the larger magnitude.
  - S_NORM (edge N+3):
    - Carry set: shift right 1, exponent+1.
    - Otherwise use leading-one detect and left-shift until the hidden bit is set or the exponent reaches -14 (denormal).
    - Truncate guard/sticky bits and encode.
    - Update the accumulator; cnt_o increments, saturating.
    - If last was latched, go to S_OUT; else go to S_IDLE.
  - S_OUT: acc_valid_o=1, prod_ready_o=0. acc_o holds stable until acc_ready_i.
    - On the handshake edge: accumulator=+0, cnt_o=0, ovf_o=0, last=0, go to S_IDLE.
- Timing:
  - Latency from accept edge N to acc_valid_o visible is 3 edges (valid after edge N+3).
  - Throughput is one product per 4 cycles.
  - acc_o mirrors the accumulator at all times; it is only qualified in S_OUT.
- Arithmetic rules:
  - Exact cancellation gives +0.
  - -0 plus -0 gives -0.
  - Zero operands pass through; the add of the other operand is exact.
- Saturation:
  - If the normalized exponent exceeds 15, or any input has exponent field 31: accumulator={sign,15'h7FFF} and ovf_o=1.
  - While ovf_o=1, further products are accepted and counted but the accumulator is unchanged.
- Underflow below the minimum denormal truncates to ±0, keeping the sign of the larger operand.
- No empty packet: every packet contains at least one product.

Optional Feature:
- FPACC_RNE_EN defined: S_NORM rounds to nearest-even using guard/round/sticky.
  - A round carry renormalizes.
  - Rounding past max finite saturates and sets ovf_o.
- Undefined: truncation (round toward zero), matching the multiplier.

Decomposition:
- Shared package fp16_pkg contains:
  - EXP_W=5, FRAC_W=10, EXP_BIAS=15, EMIN=-14, SAT_MAG=15'h7FFF;
  - an unpacked-operand struct (sign, exp, sig);
  - the state enum.
- Sub-module fpacc_lod: leading-one detector over the 12-bit pre-normalization significand; returns the left-shift amount and a zero flag.

Test Plan:
- 0x3C00 (no last), then 0x4000 with last → acc_o=0x4200, cnt_o=2, ovf_o=0.
  - acc_valid_o rises exactly 3 edges after the second accept.
- 0x3C00 then 0xBC00 last → acc_o=0x0000 (+0).
- 0x7BFF then 0x7BFF last → acc_o=0x7FFF, ovf_o=1.
  - Then a new packet 0x3C00 last → 0x3C00, ovf_o=0.
- Denormals 0x0001 then 0x0001 last → 0x0002.
  - 0x03FF then 0x0001 last → 0x0400.
- 0x3C00 then 0x1200 last → 0x3C00 without FPACC_RNE_EN, 0x3C01 with it.
- Backpressure: hold acc_ready_i=0 for 5 cycles in S_OUT.
  - acc_o and acc_valid_o stay stable and prod_ready_o=0.
  - Assert rstn_i=0 mid-S_ALIGN → next cycle all outputs at reset values, prod_ready_o=1.
